// File: rtl/image_mem_pkg.sv
// Shared constants and arbiter state type for the image RAM window.
package image_mem_pkg;
  localparam int unsigned PROC_BASE  = 120;
  localparam int unsigned ORIG_BASE  = 160120;
  localparam int unsigned WIN_END    = 320119;
  localparam int unsigned IMG_PIXELS = 160000;
  localparam int unsigned RAM_DEPTH  = 320000;
  localparam int unsigned RAM_AW     = $clog2(RAM_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    ISSUE_CPU,
    ISSUE_DISP,
    RESP_CPU,
    RESP_DISP,
    ERR_CPU,
    ERR_DISP
  } arb_state_t;
endpackage

// File: rtl/image_addr_map.sv
// Combinational translation of CPU IO addresses and display pixel indices
// into image RAM word addresses, with in-window flags.
module image_addr_map
  import image_mem_pkg::*;
(
  input  logic [21:0] cpu_addr,
  input  logic        disp_sel,
  input  logic [17:0] disp_idx,
  output logic [18:0] cpu_ram_addr,
  output logic        cpu_in_range,
  output logic [18:0] disp_ram_addr,
  output logic        disp_in_range
);
  // Processed and original images are contiguous in both spaces, so one offset covers both.
  assign cpu_in_range  = (cpu_addr >= 22'(PROC_BASE)) && (cpu_addr <= 22'(WIN_END));
  assign cpu_ram_addr  = RAM_AW'(cpu_addr - 22'(PROC_BASE));

  assign disp_in_range = disp_idx < 18'(IMG_PIXELS);
  assign disp_ram_addr = {1'b0, disp_idx} + (disp_sel ? RAM_AW'(ORIG_BASE - PROC_BASE) : '0);
endmodule

// File: rtl/image_mem_arbiter.sv
// Two-requester arbiter for the single-port image RAM: display has priority,
// the CPU is guaranteed a grant after STARVE_LIMIT consecutive display grants.
module image_mem_arbiter
  import image_mem_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [21:0]       cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  input  logic              disp_req,
  input  logic              disp_sel,
  input  logic [17:0]       disp_idx,
  output logic [DATA_W-1:0] disp_rdata,
  output logic              disp_ack,
  output logic              ram_en,
  output logic              ram_we,
  output logic [18:0]       ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);
  arb_state_t        state_reg;
  logic [2:0]        starve_cnt_reg;
  logic              ram_en_reg, ram_we_reg;
  logic [18:0]       ram_addr_reg;
  logic [DATA_W-1:0] ram_wdata_reg;
  logic              cpu_ack_reg, cpu_err_reg, disp_ack_reg;
  logic              cpu_rd_valid_reg, disp_rd_valid_reg;

  logic [18:0] cpu_ram_addr, disp_ram_addr;
  logic        cpu_in_range, disp_in_range;
  logic        arb_open, cpu_pend, disp_pend, at_limit, grant_cpu, grant_disp;

  image_addr_map u_addr_map (
    .cpu_addr      (cpu_addr),
    .disp_sel      (disp_sel),
    .disp_idx      (disp_idx),
    .cpu_ram_addr  (cpu_ram_addr),
    .cpu_in_range  (cpu_in_range),
    .disp_ram_addr (disp_ram_addr),
    .disp_in_range (disp_in_range)
  );

  // A requester whose ack is pulsing is still holding req; it must not be re-granted.
  assign arb_open   = (state_reg == IDLE) || (state_reg == RESP_CPU) || (state_reg == RESP_DISP);
  assign cpu_pend   = arb_open && cpu_req && (state_reg != RESP_CPU);
  assign disp_pend  = arb_open && disp_req && (state_reg != RESP_DISP);
  assign at_limit   = starve_cnt_reg == 3'(STARVE_LIMIT);
  assign grant_cpu  = cpu_pend && (!disp_pend || at_limit);
  assign grant_disp = disp_pend && !grant_cpu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= IDLE;
      starve_cnt_reg    <= '0;
      ram_en_reg        <= 1'b0;
      ram_we_reg        <= 1'b0;
      ram_addr_reg      <= '0;
      ram_wdata_reg     <= '0;
      cpu_ack_reg       <= 1'b0;
      cpu_err_reg       <= 1'b0;
      disp_ack_reg      <= 1'b0;
      cpu_rd_valid_reg  <= 1'b0;
      disp_rd_valid_reg <= 1'b0;
    end else begin
      ram_en_reg        <= 1'b0;
      ram_we_reg        <= 1'b0;
      ram_addr_reg      <= '0;
      ram_wdata_reg     <= '0;
      cpu_ack_reg       <= 1'b0;
      cpu_err_reg       <= 1'b0;
      disp_ack_reg      <= 1'b0;
      cpu_rd_valid_reg  <= 1'b0;
      disp_rd_valid_reg <= 1'b0;

      if (!cpu_req || grant_cpu) begin
        starve_cnt_reg <= '0;
      end else if (grant_disp && !at_limit) begin
        starve_cnt_reg <= starve_cnt_reg + 3'd1;
      end

      case (state_reg)
        ISSUE_CPU: begin
          state_reg        <= RESP_CPU;
          cpu_ack_reg      <= 1'b1;
          cpu_rd_valid_reg <= !ram_we_reg;
        end
        ISSUE_DISP: begin
          state_reg         <= RESP_DISP;
          disp_ack_reg      <= 1'b1;
          disp_rd_valid_reg <= 1'b1;
        end
        ERR_CPU, ERR_DISP: state_reg <= IDLE;
        default: begin
          if (grant_cpu && cpu_in_range) begin
            state_reg     <= ISSUE_CPU;
            ram_en_reg    <= 1'b1;
            ram_we_reg    <= cpu_we;
            ram_addr_reg  <= cpu_ram_addr;
            ram_wdata_reg <= cpu_we ? cpu_wdata : '0;
          end else if (grant_cpu) begin
            state_reg   <= ERR_CPU;
            cpu_ack_reg <= 1'b1;
            cpu_err_reg <= 1'b1;
          end else if (grant_disp && disp_in_range) begin
            state_reg    <= ISSUE_DISP;
            ram_en_reg   <= 1'b1;
            ram_addr_reg <= disp_ram_addr;
          end else if (grant_disp) begin
            state_reg    <= ERR_DISP;
            disp_ack_reg <= 1'b1;
          end else begin
            state_reg <= IDLE;
          end
        end
      endcase
    end
  end

  assign ram_en     = ram_en_reg;
  assign ram_we     = ram_we_reg;
  assign ram_addr   = ram_addr_reg;
  assign ram_wdata  = ram_wdata_reg;
  assign cpu_ack    = cpu_ack_reg;
  assign cpu_err    = cpu_err_reg;
  assign disp_ack   = disp_ack_reg;
  // RAM read data arrives during the RESP cycle itself, so it is gated rather than re-registered.
  assign cpu_rdata  = cpu_rd_valid_reg ? ram_rdata : '0;
  assign disp_rdata = disp_rd_valid_reg ? ram_rdata : '0;
endmodule

// File: tb/tb_image_mem_arbiter.sv
// Self-checking bench for image_mem_arbiter: directed scenarios plus a
// randomized two-requester run against a memory scoreboard.
module tb_image_mem_arbiter;
  localparam int DATA_W = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cpu_req = 1'b0, cpu_we = 1'b0;
  logic [21:0]       cpu_addr = '0;
  logic [DATA_W-1:0] cpu_wdata = '0;
  logic [DATA_W-1:0] cpu_rdata;
  logic              cpu_ack, cpu_err;
  logic              disp_req = 1'b0, disp_sel = 1'b0;
  logic [17:0]       disp_idx = '0;
  logic [DATA_W-1:0] disp_rdata;
  logic              disp_ack;
  logic              ram_en, ram_we;
  logic [18:0]       ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata = '0;

  int checks = 0;
  int passed = 0;
  bit mon_en = 1'b0;

  always #5 clk = ~clk;

  image_mem_arbiter #(.DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_err(cpu_err),
    .disp_req(disp_req), .disp_sel(disp_sel), .disp_idx(disp_idx),
    .disp_rdata(disp_rdata), .disp_ack(disp_ack),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  // RAM contents before any write are a fixed function of the word address.
  function automatic logic [7:0] init_val(int a);
    return 8'(a) ^ 8'(a >> 8) ^ 8'hA5;
  endfunction

  logic [7:0] mem [int];
  logic [7:0] shadow [int];

  function automatic logic [7:0] ram_peek(int a);
    if (mem.exists(a)) return mem[a];
    return init_val(a);
  endfunction

  function automatic logic [7:0] shadow_peek(int a);
    if (shadow.exists(a)) return shadow[a];
    return init_val(a);
  endfunction

  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) mem[int'(ram_addr)] = ram_wdata;
      else ram_rdata <= ram_peek(int'(ram_addr));
    end
  end

  // Window map straight from the address rules: -1 means out of window.
  function automatic int cpu_map(int a);
    if (a < 120 || a > 320119) return -1;
    return a - 120;
  endfunction

  function automatic int disp_map(bit sel, int idx);
    if (idx >= 160000) return -1;
    return idx + (sel ? 160000 : 0);
  endfunction

  // Protocol monitor used during the free-running random phase.
  bit prev_en_m = 1'b0, prev_cack_m = 1'b0, prev_dack_m = 1'b0;
  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ((ram_en && prev_en_m) !== 1'b0) $display("FAIL mon_ram_en_consecutive got=1 want=0");
      else passed++;
      checks++;
      if ((cpu_ack && disp_ack) !== 1'b0) $display("FAIL mon_ack_overlap got=1 want=0");
      else passed++;
      checks++;
      if (((cpu_ack && prev_cack_m) || (disp_ack && prev_dack_m)) !== 1'b0)
        $display("FAIL mon_ack_width got=2cycles want=1cycle");
      else passed++;
    end
    prev_en_m   = ram_en;
    prev_cack_m = cpu_ack;
    prev_dack_m = disp_ack;
  end

  task automatic test_reset();
    bit any_ack;
    rst = 1'b1; cpu_req = 1'b0; disp_req = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_err, cpu_rdata, disp_ack, disp_rdata} !== '0)
      $display("FAIL reset_outputs got=%h want=0",
               {ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_err, cpu_rdata, disp_ack, disp_rdata});
    else passed++;
    rst = 1'b0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'(120 + 77); cpu_wdata = 8'h33;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we} !== 2'b11) $display("FAIL reset_issue_before got=%b want=11", {ram_en, ram_we});
    else passed++;
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_err, cpu_rdata, disp_ack, disp_rdata} !== '0)
      $display("FAIL reset_async_clear got=%h want=0",
               {ram_en, ram_we, ram_addr, ram_wdata, cpu_ack, cpu_err, cpu_rdata, disp_ack, disp_rdata});
    else passed++;
    cpu_req = 1'b0;
    any_ack = 1'b0;
    repeat (3) begin
      @(negedge clk);
      any_ack |= cpu_ack;
    end
    rst = 1'b0;
    @(negedge clk);
    any_ack |= cpu_ack;
    checks++;
    if (any_ack !== 1'b0) $display("FAIL reset_no_ack got=1 want=0");
    else passed++;
    // A fresh read must follow the normal IDLE latency.
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'(120 + 500);
    @(negedge clk);
    checks++;
    if ({ram_en, ram_addr} !== {1'b1, 19'd500}) $display("FAIL reset_idle_issue got=%b/%0d want=1/500", ram_en, ram_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, shadow_peek(500)})
      $display("FAIL reset_idle_ack got=%b/%h want=1/%h", cpu_ack, cpu_rdata, shadow_peek(500));
    else passed++;
    cpu_req = 1'b0;
    @(negedge clk);
    $display("txn reset: mid-write reset aborted, post-reset read ok");
  endtask

  task automatic test_cpu_round_trip();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 22'd120; cpu_wdata = 8'h5A;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr, ram_wdata, cpu_ack} !== {1'b1, 1'b1, 19'd0, 8'h5A, 1'b0})
      $display("FAIL rt_write_issue got=%b%b/%0d/%h/%b want=11/0/5a/0", ram_en, ram_we, ram_addr, ram_wdata, cpu_ack);
    else passed++;
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_err, cpu_rdata, ram_en} !== {1'b1, 1'b0, 8'h00, 1'b0})
      $display("FAIL rt_write_ack got=%b%b/%h/%b want=10/00/0", cpu_ack, cpu_err, cpu_rdata, ram_en);
    else passed++;
    shadow[0] = 8'h5A;
    cpu_req = 1'b0;
    $display("txn cpu write addr=120 data=5a");
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'd320119;
    @(negedge clk);
    checks++;
    if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 19'd319999})
      $display("FAIL rt_read_issue got=%b%b/%0d want=10/319999", ram_en, ram_we, ram_addr);
    else passed++;
    @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b0, shadow_peek(319999)})
      $display("FAIL rt_read_ack got=%b%b/%h want=10/%h", cpu_ack, cpu_err, cpu_rdata, shadow_peek(319999));
    else passed++;
    cpu_req = 1'b0;
    $display("txn cpu read addr=320119 data=%h", cpu_rdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_addr = 22'd120;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_ack, cpu_rdata} !== {1'b1, 8'h5A}) $display("FAIL rt_readback got=%b/%h want=1/5a", cpu_ack, cpu_rdata);
    else passed++;
    cpu_req = 1'b0;
    $display("txn cpu read addr=120 data=%h", cpu_rdata);
    @(negedge clk);
  endtask

  task automatic test_out_of_window();
    int addrs [3] = '{96, 119, 320120};
    bit en_seen;
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'(addrs[i]);
      @(negedge clk);
      en_seen = ram_en;
      checks++;
      if ({cpu_ack, cpu_err, cpu_rdata} !== {1'b1, 1'b1, 8'h00})
        $display("FAIL oow_ack_%0d got=%b%b/%h want=11/00", addrs[i], cpu_ack, cpu_err, cpu_rdata);
      else passed++;
      cpu_req = 1'b0;
      @(negedge clk);
      en_seen |= ram_en;
      checks++;
      if ({cpu_ack, en_seen} !== 2'b00) $display("FAIL oow_quiet_%0d got=%b want=00", addrs[i], {cpu_ack, en_seen});
      else passed++;
      $display("txn cpu read addr=%0d err", addrs[i]);
    end
  endtask

  task automatic test_disp_mapping();
    bit sels [3] = '{1'b1, 1'b0, 1'b0};
    int idxs [3] = '{0, 159999, 160000};
    int exp_a;
    for (int i = 0; i < 3; i++) begin
      exp_a = disp_map(sels[i], idxs[i]);
      disp_req = 1'b1; disp_sel = sels[i]; disp_idx = 18'(idxs[i]);
      @(negedge clk);
      if (exp_a >= 0) begin
        checks++;
        if ({ram_en, ram_we, ram_addr} !== {1'b1, 1'b0, 19'(exp_a)})
          $display("FAIL dmap_issue_%0d got=%b%b/%0d want=10/%0d", i, ram_en, ram_we, ram_addr, exp_a);
        else passed++;
        @(negedge clk);
        checks++;
        if ({disp_ack, disp_rdata} !== {1'b1, shadow_peek(exp_a)})
          $display("FAIL dmap_ack_%0d got=%b/%h want=1/%h", i, disp_ack, disp_rdata, shadow_peek(exp_a));
        else passed++;
      end else begin
        checks++;
        if ({disp_ack, disp_rdata, ram_en} !== {1'b1, 8'h00, 1'b0})
          $display("FAIL dmap_oor got=%b/%h/%b want=1/00/0", disp_ack, disp_rdata, ram_en);
        else passed++;
      end
      disp_req = 1'b0;
      $display("txn disp sel=%0d idx=%0d data=%h", sels[i], idxs[i], disp_rdata);
      @(negedge clk);
      checks++;
      if ({disp_ack, ram_en} !== 2'b00) $display("FAIL dmap_after_%0d got=%b want=00", i, {disp_ack, ram_en});
      else passed++;
    end
  endtask

  // Out-of-range display requests return to IDLE, so held requests exercise the starvation counter.
  task automatic test_starvation();
    int seq[$];
    int gap, max_gap;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'(120 + 1000);
    disp_req = 1'b1; disp_sel = 1'b0; disp_idx = 18'd200000;
    gap = 0; max_gap = 0;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      gap++;
      if (disp_ack) seq.push_back(0);
      if (cpu_ack) begin
        seq.push_back(1);
        if (gap > max_gap) max_gap = gap;
        gap = 0;
      end
    end
    cpu_req = 1'b0; disp_req = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (seq.size() < 10) $display("FAIL starve_count got=%0d want>=10", seq.size());
    else begin
      passed++;
      for (int i = 0; i < 10; i++) begin
        checks++;
        if (seq[i] !== ((i % 5 == 4) ? 1 : 0))
          $display("FAIL starve_order_%0d got=%s want=%s", i, seq[i] ? "C" : "D", (i % 5 == 4) ? "C" : "D");
        else passed++;
      end
    end
    checks++;
    if (max_gap > 10 || max_gap == 0) $display("FAIL starve_cpu_gap got=%0d want=1..10", max_gap);
    else passed++;
    $display("txn starvation: %0d grants, max cpu gap %0d", seq.size(), max_gap);
  endtask

  task automatic test_back_to_back();
    logic [2:0] obs, exp;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 22'(120 + 2000);
    disp_req = 1'b1; disp_sel = 1'b1; disp_idx = 18'd3000;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      obs = {ram_en, disp_ack, cpu_ack};
      exp = {c[0], c % 4 == 2, c % 4 == 0};
      checks++;
      if (obs !== exp) $display("FAIL b2b_cycle_%0d got=%b want=%b", c, obs, exp);
      else passed++;
      if (disp_ack) begin
        checks++;
        if (disp_rdata !== shadow_peek(163000)) $display("FAIL b2b_disp_data got=%h want=%h", disp_rdata, shadow_peek(163000));
        else passed++;
      end
      if (cpu_ack) begin
        checks++;
        if (cpu_rdata !== shadow_peek(2000)) $display("FAIL b2b_cpu_data got=%h want=%h", cpu_rdata, shadow_peek(2000));
        else passed++;
      end
    end
    cpu_req = 1'b0; disp_req = 1'b0;
    repeat (3) @(negedge clk);
    $display("txn back-to-back: 20 cycles alternating D/C");
  endtask

  task automatic cpu_driver(int n);
    int a, m, sel;
    bit we, got, p_en, p_we;
    logic [7:0] wd, exp_rd;
    logic [18:0] p_addr;
    logic [7:0] p_wd;
    int pool [8] = '{125, 126, 127, 128, 160131, 160132, 160119, 320119};
    for (int t = 0; t < n; t++) begin
      sel = $urandom_range(9, 0);
      if (sel == 0) a = $urandom_range(119, 0);
      else if (sel == 1) a = $urandom_range(4194303, 320120);
      else a = pool[$urandom_range(7, 0)];
      we = 1'($urandom_range(1, 0));
      wd = 8'($urandom);
      m = cpu_map(a);
      cpu_addr = 22'(a); cpu_we = we; cpu_wdata = wd; cpu_req = 1'b1;
      got = 1'b0; p_en = 1'b0; p_we = 1'b0; p_addr = '0; p_wd = '0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (cpu_ack) begin
          got = 1'b1;
          exp_rd = (m < 0 || we) ? 8'h00 : shadow_peek(m);
          checks++;
          if ({cpu_err, cpu_rdata} !== {m < 0, exp_rd})
            $display("FAIL rnd_cpu_resp addr=%0d got=%b/%h want=%b/%h", a, cpu_err, cpu_rdata, m < 0, exp_rd);
          else passed++;
          checks++;
          if (m < 0) begin
            if (p_en !== 1'b0) $display("FAIL rnd_cpu_noaccess addr=%0d got=1 want=0", a);
            else passed++;
          end else begin
            if ({p_en, p_we, p_addr, p_wd} !== {1'b1, we, 19'(m), we ? wd : p_wd})
              $display("FAIL rnd_cpu_bus addr=%0d got=%b%b/%0d/%h want=1%b/%0d/%h", a, p_en, p_we, p_addr, p_wd, we, m, wd);
            else passed++;
          end
          $display("txn cpu %0d addr=%0d we=%0d wdata=%h rdata=%h err=%0d", t, a, we, wd, cpu_rdata, cpu_err);
        end else begin
          p_en = ram_en; p_we = ram_we; p_addr = ram_addr; p_wd = ram_wdata;
        end
      end
      checks++;
      if (!got) $display("FAIL rnd_cpu_timeout addr=%0d got=noack want=ack", a);
      else passed++;
      cpu_req = 1'b0;
      if (got && we && m >= 0) shadow[m] = wd;
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  task automatic disp_driver(int n);
    int idx, m;
    bit s, got, p_en, p_we;
    logic [18:0] p_addr;
    logic [7:0] exp_rd;
    for (int t = 0; t < n; t++) begin
      s = 1'($urandom_range(1, 0));
      idx = ($urandom_range(7, 0) == 0) ? $urandom_range(262143, 160000) : $urandom_range(199, 100);
      m = disp_map(s, idx);
      disp_sel = s; disp_idx = 18'(idx); disp_req = 1'b1;
      got = 1'b0; p_en = 1'b0; p_we = 1'b0; p_addr = '0;
      for (int c = 0; c < 40 && !got; c++) begin
        @(negedge clk);
        if (disp_ack) begin
          got = 1'b1;
          exp_rd = (m < 0) ? 8'h00 : shadow_peek(m);
          checks++;
          if (disp_rdata !== exp_rd) $display("FAIL rnd_disp_data idx=%0d got=%h want=%h", idx, disp_rdata, exp_rd);
          else passed++;
          checks++;
          if ({p_en, p_we, p_addr} !== ((m < 0) ? {2'b00, p_addr} : {2'b10, 19'(m)}))
            $display("FAIL rnd_disp_bus idx=%0d got=%b%b/%0d want_map=%0d", idx, p_en, p_we, p_addr, m);
          else passed++;
          $display("txn disp %0d sel=%0d idx=%0d rdata=%h", t, s, idx, disp_rdata);
        end else begin
          p_en = ram_en; p_we = ram_we; p_addr = ram_addr;
        end
      end
      checks++;
      if (!got) $display("FAIL rnd_disp_timeout idx=%0d got=noack want=ack", idx);
      else passed++;
      disp_req = 1'b0;
      repeat ($urandom_range(2, 0)) @(negedge clk);
    end
  endtask

  task automatic test_random();
    mon_en = 1'b1;
    fork
      cpu_driver(40);
      disp_driver(40);
    join
    @(negedge clk);
    mon_en = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_cpu_round_trip();
    test_out_of_window();
    test_disp_mapping();
    test_starvation();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
